// File: rtl/vga_pwm_recover.sv
// Rebuilds 24-bit RGB from a 4-phase temporally dithered 18-bit stream by summing each x over 4 lines.
// Optional VGA_PWM_RECOVER_HOLD_EN: hold RAM replays the last reconstruction on phase 0..2 lines.

module vga_pwm_ch (
  input  logic [5:0] c6,
  input  logic [7:0] s,
  input  logic       first,
  output logic [7:0] wsum,
  output logic [7:0] rec,
  output logic [7:0] raw
);
  logic [7:0] total;

  always_comb begin
    total = s + {2'b00, c6};
    wsum  = first ? {2'b00, c6} : total;
    // 4 x 63 = 252 is the only way to reach 252, so it stands for full-scale white
    rec   = (total == 8'd252 && c6 == 6'd63) ? 8'hFF : total;
    raw   = {c6, c6[5:4]};
  end
endmodule

module vga_pwm_recover #(
  parameter int MAX_WIDTH = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [17:0] din,
  output logic [23:0] dout,
  output logic        dout_de,
  output logic        dout_hs,
  output logic        dout_vs,
  output logic        dout_valid,
  output logic [1:0]  phase
);
  localparam int NCH = 3;
  localparam int XW  = $clog2(MAX_WIDTH + 1);
  localparam logic [XW-1:0] XMAX = XW'(MAX_WIDTH);

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          en;
    logic          inr;
    logic [1:0]    ph;
    logic [AW-1:0] addr;
    logic [17:0]   pix;
`ifdef VGA_PWM_RECOVER_HOLD_EN
    logic          held;
`endif
  } s1_t;

  logic          hs_q, vs_q, de_q;
  logic [1:0]    phase_q, phase_d;
  logic [XW-1:0] x_q, x_d, x_cur;
  logic          hs_fall, vs_fall, in_range;
  s1_t           s1_q, s1_d;

  logic [23:0] dout_q, dout_d;
  logic        dout_de_q, dout_de_d;
  logic        dout_hs_q, dout_hs_d;
  logic        dout_vs_q, dout_vs_d;
  logic        dout_valid_q, dout_valid_d;

  logic [23:0]            sum_mem [MAX_WIDTH];
  logic [23:0]            sum_rd_q;
  logic                   sum_we, rec_path;
  logic [NCH-1:0][7:0]    wsum, rec, raw;

`ifdef VGA_PWM_RECOVER_HOLD_EN
  logic [23:0] hold_mem [MAX_WIDTH];
  logic [23:0] hold_rd_q;
  logic        hold_we;
  logic        held_q, held_d;
`endif

  // Stage 0: sync edges, phase and x tracking, RAM read issue
  always_comb begin
    hs_fall  = hs_q & ~hsync;
    vs_fall  = vs_q & ~vsync;
    phase_d  = phase_q;
    if (vs_fall)      phase_d = 2'd0;
    else if (hs_fall) phase_d = phase_q + 2'd1;

    x_cur    = (de && !de_q) ? '0 : x_q;
    in_range = (x_cur < XMAX);
    x_d      = x_q;
    if (de) x_d = (x_cur == XMAX) ? x_cur : x_cur + 1'b1;

    s1_d      = '0;
    s1_d.de   = de;
    s1_d.hs   = hsync;
    s1_d.vs   = vsync;
    s1_d.en   = en;
    s1_d.inr  = de & in_range;
    s1_d.ph   = phase_q;
    s1_d.addr = in_range ? AW'(x_cur) : '0;
    s1_d.pix  = din;
`ifdef VGA_PWM_RECOVER_HOLD_EN
    s1_d.held = held_q;
    held_d    = held_q;
    if (vs_fall)                        held_d = 1'b0;
    else if (hs_fall && phase_q == 2'd3) held_d = 1'b1;
`endif
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    vga_pwm_ch u_ch (
      .c6    (s1_q.pix[6*i +: 6]),
      .s     (sum_rd_q[8*i +: 8]),
      .first (s1_q.ph == 2'd0),
      .wsum  (wsum[i]),
      .rec   (rec[i]),
      .raw   (raw[i])
    );
  end

  // Stage 1: write back partial sums and pick the output pixel
  always_comb begin
    rec_path     = s1_q.en & s1_q.inr;
    sum_we       = s1_q.de & rec_path & (s1_q.ph != 2'd3);
    dout_d       = '0;
    dout_valid_d = 1'b0;
    dout_de_d    = s1_q.de;
    dout_hs_d    = s1_q.hs;
    dout_vs_d    = s1_q.vs;
`ifdef VGA_PWM_RECOVER_HOLD_EN
    hold_we      = s1_q.de & rec_path & (s1_q.ph == 2'd3);
`endif
    if (s1_q.de) begin
      if (rec_path && s1_q.ph == 2'd3) begin
        dout_d       = rec;
        dout_valid_d = 1'b1;
      end
`ifdef VGA_PWM_RECOVER_HOLD_EN
      else if (rec_path) begin
        dout_d       = hold_rd_q;
        dout_valid_d = s1_q.held;
      end
`endif
      else begin
        dout_d = raw;
      end
    end
  end

  // Read-modify-write never collides: the write lags the read by one pixel
  always_ff @(posedge clk) begin
    if (sum_we) sum_mem[s1_q.addr] <= wsum;
    sum_rd_q <= sum_mem[s1_d.addr];
  end

`ifdef VGA_PWM_RECOVER_HOLD_EN
  always_ff @(posedge clk) begin
    if (hold_we) hold_mem[s1_q.addr] <= rec;
    hold_rd_q <= hold_mem[s1_d.addr];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      phase_q      <= 2'd0;
      x_q          <= '0;
      s1_q         <= '0;
      s1_q.hs      <= 1'b1;
      s1_q.vs      <= 1'b1;
      dout_q       <= '0;
      dout_de_q    <= 1'b0;
      dout_hs_q    <= 1'b1;
      dout_vs_q    <= 1'b1;
      dout_valid_q <= 1'b0;
`ifdef VGA_PWM_RECOVER_HOLD_EN
      held_q       <= 1'b0;
`endif
    end else begin
      hs_q         <= hsync;
      vs_q         <= vsync;
      de_q         <= de;
      phase_q      <= phase_d;
      x_q          <= x_d;
      s1_q         <= s1_d;
      dout_q       <= dout_d;
      dout_de_q    <= dout_de_d;
      dout_hs_q    <= dout_hs_d;
      dout_vs_q    <= dout_vs_d;
      dout_valid_q <= dout_valid_d;
`ifdef VGA_PWM_RECOVER_HOLD_EN
      held_q       <= held_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_de    = dout_de_q;
  assign dout_hs    = dout_hs_q;
  assign dout_vs    = dout_vs_q;
  assign dout_valid = dout_valid_q;
  assign phase      = phase_q;
endmodule

// File: doc/vga_pwm_recover.md
Name: vga_pwm_recover

Overview:
- Receive-side companion to the 18-bit temporal-dither output stage.
- Takes the 6-bit-per-channel dithered pixel stream (R[17:12], G[11:6], B[5:0]) plus syncs/DE.
- Sums each pixel position over 4 consecutive lines (dither phases 0..3) in a line RAM and rebuilds 24-bit RGB.
- Sits on the capture/loopback path for scaler verification and analog-out self-test.

Parameters:
- MAX_WIDTH, 1024, line RAM depth (max active pixels per line).
- AW, 10, RAM address width; MAX_WIDTH <= 2**AW.

Ports:
- clk  in  1  pixel clock, single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  1 = recover, 0 = bypass (raw expansion).
- de  in  1  active video.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- din  in  18  dithered pixel {R6,G6,B6}.
- dout  out  24  recovered pixel {R8,G8,B8}.
- dout_de  out  1  de delayed to align with dout.
- dout_hs  out  1  hsync delayed to align with dout.
- dout_vs  out  1  vsync delayed to align with dout.
- dout_valid  out  1  dout is a full 4-line reconstruction.
- phase  out  2  current line dither phase.

Behaviour:
- Reset (async, reset_n=0): dout=0, dout_de=0, dout_hs=1, dout_vs=1, dout_valid=0, phase=0, x counter=0, pipeline cleared. RAM contents are not cleared; phase-0 overwrite makes the stale data irrelevant.
- Edge detect uses registered hsync/vsync, reset value 1.
  - vsync falling edge: phase<=0.
  - Else hsync falling edge: phase<=phase+1, wrapping 3->0.
  - Simultaneous vsync and hsync falling edges: vsync wins, phase=0.
- x counter: cleared on de rising edge; increments each de=1 cycle; saturates at MAX_WIDTH. Pixels with x>=MAX_WIDTH are not written and output raw expansion with dout_valid=0.
- RAM: depth MAX_WIDTH, 24 bits = three 8-bit partial sums. Synchronous read, read-modify-write in a 2-stage pipeline.
  - Stage 1: issue read at x.
  - Stage 2: form partial sum and write back to the same x.
  - Back-to-back x never collides, because consecutive cycles use distinct addresses.
- Per channel c6 (6-bit), with stored partial s:
  - phase 0: s<=c6 (overwrite).
  - phase 1,2: s<=s+c6. Max 189, fits 8 bits.
  - phase 3: total = s+c6 (0..252).
    - If all four samples equal 63 (tracked by a per-channel 1-bit flag, forced when total==252 and c6==63), output 8'hFF.
    - Otherwise output total[7:0].
- Output on en=1, de=1, phase 3, x<MAX_WIDTH: dout=recovered value, dout_valid=1.
- Output on other de=1 cycles: dout=raw expansion {c6,c6[5:4]} per channel, dout_valid=0.
- Output on de=0: dout=0, dout_valid=0.
- en=0: phase and x keep tracking; RAM is not written; dout=raw expansion; dout_valid=0.
- Latency: fixed 2 clk from din/de/hsync/vsync to dout/dout_de/dout_hs/dout_vs, in all modes.
- A line shorter than the previous one leaves stale tail entries; these are overwritten on the next phase-0 line.
- Reset mid-line: pipeline flushes; the first reconstruction appears on the 4th line after vsync.

Optional Feature:
- Macro: VGA_PWM_RECOVER_HOLD_EN.
- Defined: adds a second MAX_WIDTH x 24 RAM written with the reconstructed value on phase-3 lines.
  - On phase 0..2 lines, dout is read from this RAM at x.
  - dout_valid=1 once any phase-3 line has completed since reset or the last vsync; 0 before that.
- Undefined: no hold RAM; phase 0..2 lines output raw expansion as above.

Test Plan:
- Constant din R6=G6=B6=6'd32 on all 4 phases, en=1 -> phase-3 dout=24'h808080, dout_valid=1; phase 0..2 dout=24'h828282, dout_valid=0.
- Dithered 8-bit 8'h81 (R6 samples 33,32,32,32) over phases 0..3 -> phase-3 R8=8'h81, in 2-clk alignment with dout_de.
- All samples 6'd63 for 4 lines -> dout=24'hFFFFFF; samples 63,63,63,62 -> R8=8'hFB.
- vsync falling edge in the same cycle as hsync falling edge, after phase 2 -> phase=0; next line overwrites RAM; no dout_valid until 4 lines later.
- Assert reset_n=0 mid-line at phase 2, release -> all outputs at reset values immediately; phase=0 after release; first dout_valid on the 4th subsequent line.
- en=0 with din=18'h3FFFF -> dout=24'hFFFFFF, dout_valid=0, phase still increments on each hsync falling edge.
